// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: machine widths, the canonical NOP,
// the fetch/decode entry layout and the ALU operation encodings.
package riscv_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   // addi x0,x0,0 -- what decode sees when nothing real is available
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // One fetched instruction together with the PC it was fetched from
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // ALUControl encodings shared by alu2 and its users
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_op_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch-side handshake, decode-side handshake,
// flush request and occupancy status.
interface if_id_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int ILEN  = 32
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc;
   logic [ILEN-1:0]  in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_pc_plus4;
   logic [ILEN-1:0]  out_instr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;

   // The side that drives instructions in, consumes them and requests flushes
   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr,
             count, full, empty
   );

   // The queue itself
   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_pc_plus4, out_instr,
             count, full, empty
   );

endinterface

// File: rtl/if_id_queue_alu2.sv
// Small two-operand ALU, the same block the fetch stage uses to form PC+4.
module alu2 #(
   parameter int WIDTH = riscv_pkg::XLEN
) (
   input  riscv_pkg::alu_op_e aluControl_i,
   input  logic [WIDTH-1:0]   rs1_i,
   input  logic [WIDTH-1:0]   rs2_i,
   output logic [WIDTH-1:0]   result_o
);

   import riscv_pkg::*;

   // Select the operation; additions wrap modulo 2^WIDTH
   always_comb begin
      result_o = '0;
      case (aluControl_i)
         ALU_AND: result_o = rs1_i & rs2_i;
         ALU_OR:  result_o = rs1_i | rs2_i;
         ALU_ADD: result_o = rs1_i + rs2_i;
         ALU_SUB: result_o = rs1_i - rs2_i;
         ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Holds DEPTH {PC, instruction}
// pairs in FIFO order, decouples decode stalls from fetch, and drops every
// buffered wrong-path instruction when a redirect flush arrives.
module if_id_queue #(
   parameter int               DEPTH = 4,
   parameter int               XLEN  = riscv_pkg::XLEN,
   parameter int               ILEN  = riscv_pkg::ILEN,
   parameter logic [ILEN-1:0]  NOP   = riscv_pkg::NOP_INSTR
) (
   input logic           clk,
   input logic           reset,
   if_id_queue_if.slave  bus
);

   import riscv_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   // Same field order as fetch_entry_t, sized by this instance's parameters
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             isFull;
   logic             isEmpty;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  headPc;
   logic [ILEN-1:0]  headInstr;
   logic [XLEN-1:0]  headPcPlus4;

   // Status comes only from the registered count, so in_ready never
   // depends on out_ready and a full queue refuses input even during a pop.
   assign isFull  = (count_q == DEPTH_CNT);
   assign isEmpty = (count_q == '0);

   // Flush overrides both sides: the flush-cycle instruction is dropped
   assign push = bus.in_valid  & ~isFull  & ~bus.flush;
   assign pop  = bus.out_ready & ~isEmpty & ~bus.flush;

   // Next pointer/count values; DEPTH is a power of two so pointers wrap naturally
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (bus.flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers, cleared immediately on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are meaningless once the count says empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q].pc    <= bus.in_pc;
         mem_q[wrPtr_q].instr <= bus.in_instr;
      end
   end

   // Head view: real entry when occupied, PC 0 with a NOP otherwise
   always_comb begin
      headPc    = '0;
      headInstr = NOP;
      if (!isEmpty) begin
         headPc    = mem_q[rdPtr_q].pc;
         headInstr = mem_q[rdPtr_q].instr;
      end
   end

   alu2 #(
      .WIDTH (XLEN)
   ) u_pcPlus4 (
      .aluControl_i (ALU_ADD),
      .rs1_i        (headPc),
      .rs2_i        (XLEN'(4)),
      .result_o     (headPcPlus4)
   );

   assign bus.in_ready     = ~isFull;
   assign bus.out_valid    = ~isEmpty;
   assign bus.out_pc       = headPc;
   assign bus.out_pc_plus4 = headPcPlus4;
   assign bus.out_instr    = headInstr;
   assign bus.count        = count_q;
   assign bus.full         = isFull;
   assign bus.empty        = isEmpty;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for the fetch-to-decode instruction queue.
module tb_if_id_queue;

   import riscv_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOPI = 32'h00000013;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   if_id_queue_if #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32)) bus ();

   if_id_queue #(
      .DEPTH (DEPTH),
      .XLEN  (64),
      .ILEN  (32),
      .NOP   (NOPI)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Any comparison that disagrees is counted and reported
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive a new input set on the falling edge, then let the head settle
   task automatic applyStimulus(input logic v, input logic [63:0] pc,
                                input logic [31:0] instr, input logic rdy,
                                input logic fl);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_instr  = instr;
      bus.out_ready = rdy;
      bus.flush     = fl;
      #1;
   endtask

   // Overall time bound so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] instrTab [4];
      instrTab[0] = 32'h00500093;
      instrTab[1] = 32'h00600113;
      instrTab[2] = 32'h00700193;
      instrTab[3] = 32'h00800213;
      total = 0;
      bad   = 0;

      // Reset state while reset is held
      reset         = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_instr  = '0;
      bus.out_ready = 1'b0;
      #2;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_instr", 64'(bus.out_instr), 64'h13);
      checkOutput("rst_out_pc",    bus.out_pc, 64'd0);
      checkOutput("rst_pc_plus4",  bus.out_pc_plus4, 64'd4);
      checkOutput("rst_count",     64'(bus.count), 64'd0);
      checkOutput("rst_in_ready",  64'(bus.in_ready), 64'd1);
      checkOutput("rst_empty",     64'(bus.empty), 64'd1);
      checkOutput("rst_full",      64'(bus.full), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Fill to capacity with decode stalled
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'(4 * i), instrTab[i], 1'b0, 1'b0);
         checkOutput($sformatf("fill_count%0d", i), 64'(bus.count), 64'(i));
      end
      applyStimulus(1'b1, 64'h10, 32'h00900293, 1'b0, 1'b0);
      checkOutput("full_count",    64'(bus.count), 64'd4);
      checkOutput("full_flag",     64'(bus.full), 64'd1);
      checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("full_head_pc",  bus.out_pc, 64'd0);
      checkOutput("full_head_p4",  bus.out_pc_plus4, 64'd4);
      checkOutput("full_head_ins", 64'(bus.out_instr), 64'(instrTab[0]));

      // Fifth push was refused; offering it again alongside a pop is refused too
      applyStimulus(1'b1, 64'h10, 32'h00900293, 1'b1, 1'b0);
      checkOutput("rej_count", 64'(bus.count), 64'd4);
      checkOutput("drain_pc0", bus.out_pc, 64'd0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
         checkOutput($sformatf("drain_pc%0d", i), bus.out_pc, 64'(4 * i));
         checkOutput($sformatf("drain_ins%0d", i), 64'(bus.out_instr), 64'(instrTab[i]));
         checkOutput($sformatf("drain_cnt%0d", i), 64'(bus.count), 64'(4 - i));
      end
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("drained_empty", 64'(bus.empty), 64'd1);
      checkOutput("drained_valid", 64'(bus.out_valid), 64'd0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("underflow_cnt", 64'(bus.count), 64'd0);

      // Streaming push+pop across pointer wrap, one-cycle latency
      applyStimulus(1'b1, 64'h100, 32'h10000100, 1'b0, 1'b0);
      checkOutput("stream_lat", 64'(bus.out_valid), 64'd0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b1, 64'(256 + 4 * k), 32'h10000000 | 32'(256 + 4 * k), 1'b1, 1'b0);
         checkOutput($sformatf("stream_cnt%0d", k), 64'(bus.count), 64'd1);
         checkOutput($sformatf("stream_pc%0d", k), bus.out_pc, 64'(256 + 4 * (k - 1)));
         checkOutput($sformatf("stream_ins%0d", k), 64'(bus.out_instr),
                     64'(32'h10000000 | 32'(256 + 4 * (k - 1))));
      end
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      checkOutput("stream_last", bus.out_pc, 64'h128);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("stream_end", 64'(bus.count), 64'd0);

      // Flush with three entries held, an input offered and decode ready
      applyStimulus(1'b1, 64'h20, 32'h00000020, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h24, 32'h00000024, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h28, 32'h00000028, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h40, 32'h00000040, 1'b1, 1'b1);
      checkOutput("preflush_cnt", 64'(bus.count), 64'd3);
      checkOutput("preflush_pc",  bus.out_pc, 64'h20);
      applyStimulus(1'b1, 64'h80, 32'h00000080, 1'b0, 1'b0);
      checkOutput("flush_cnt",   64'(bus.count), 64'd0);
      checkOutput("flush_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("flush_instr", 64'(bus.out_instr), 64'h13);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("postflush_cnt", 64'(bus.count), 64'd1);
      checkOutput("postflush_pc",  bus.out_pc, 64'h80);
      checkOutput("postflush_p4",  bus.out_pc_plus4, 64'h84);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("postflush_empty", 64'(bus.empty), 64'd1);

      // Asynchronous reset between clock edges with two entries held
      applyStimulus(1'b1, 64'h200, 32'h00000200, 1'b0, 1'b0);
      applyStimulus(1'b1, 64'h204, 32'h00000204, 1'b0, 1'b0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("prereset_cnt", 64'(bus.count), 64'd2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("areset_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("areset_cnt",   64'(bus.count), 64'd0);
      checkOutput("areset_pc",    bus.out_pc, 64'd0);
      checkOutput("areset_p4",    bus.out_pc_plus4, 64'd4);
      checkOutput("areset_instr", 64'(bus.out_instr), 64'h13);
      @(negedge clk);
      reset = 1'b0;

      // PC+4 wraps at the top of the address space
      applyStimulus(1'b1, 64'hFFFFFFFFFFFFFFFC, 32'h0000006F, 1'b0, 1'b0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("wrap_pc",    bus.out_pc, 64'hFFFFFFFFFFFFFFFC);
      checkOutput("wrap_p4",    bus.out_pc_plus4, 64'd0);
      checkOutput("wrap_instr", 64'(bus.out_instr), 64'h6F);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("final_cnt", 64'(bus.count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
